seg7_pattern_capture: RTL and testbench

Recovers hex digits from an active-low seven-segment drive bus (segment order a..g on bits 1..7, digit patterns 0–F, blank = 7'h7F). The block synchronises the segment lines, waits until a pattern is stable, decodes it back to a 4-bit value and delivers each new stable pattern as a single record on a valid/ready interface. It sits on the observation side of the display path, e.g. as a self-check monitor or as a readback channel toward a host.

---
 rtl/seg7_pkg.sv | 58 +++++
 rtl/seg7_pattern_decode.sv | 18 +
 rtl/seg7_pattern_capture.sv | 129 ++++++++++++
 tb/tb_seg7_pattern_capture.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and pattern decoder for the seven-segment capture path.
// Segment patterns are active-low, bit order g..a (a is the LSB).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {TRACK, EMIT, HOLD} seg7_state_t;

  typedef struct packed {
    logic       error;
    logic       blank;
    logic [3:0] digit;
  } seg7_dec_t;

  // Digit is forced to 0 for blank and unrecognised patterns.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] pattern);
    seg7_dec_t d;
    d = '0;
    case (pattern)
      SEG_0:     d.digit = 4'h0;
      SEG_1:     d.digit = 4'h1;
      SEG_2:     d.digit = 4'h2;
      SEG_3:     d.digit = 4'h3;
      SEG_4:     d.digit = 4'h4;
      SEG_5:     d.digit = 4'h5;
      SEG_6:     d.digit = 4'h6;
      SEG_7:     d.digit = 4'h7;
      SEG_8:     d.digit = 4'h8;
      SEG_9:     d.digit = 4'h9;
      SEG_A:     d.digit = 4'hA;
      SEG_B:     d.digit = 4'hB;
      SEG_C:     d.digit = 4'hC;
      SEG_D:     d.digit = 4'hD;
      SEG_E:     d.digit = 4'hE;
      SEG_F:     d.digit = 4'hF;
      SEG_BLANK: d.blank = 1'b1;
      default:   d.error = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational wrapper that turns one sampled segment pattern into {error, blank, digit}.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:1] i_pattern,
  output logic [3:0] o_digit,
  output logic       o_blank,
  output logic       o_error
);

  seg7_dec_t w_dec;

  assign w_dec   = seg7_decode(i_pattern);
  assign o_digit = w_dec.digit;
  assign o_blank = w_dec.blank;
  assign o_error = w_dec.error;

endmodule

// File: rtl/seg7_pattern_capture.sv
// Recovers hex digits from an active-low seven-segment bus and emits one valid/ready record per new stable pattern.
// Define SEG7_BLANK_REPORT_EN to emit records for the blank pattern; otherwise blanks are tracked silently.
module seg7_pattern_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:1] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_blank,
  output logic       out_error,
  output logic       overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [7:1]       r_sync1, r_sync2, r_prev;
  logic [7:1]       r_lastReported, r_held;
  logic             r_hasReported;
  logic [CNT_W-1:0] r_count;
  seg7_state_t      r_state;

  logic [3:0] w_digit;
  logic       w_blank, w_error;
  logic       w_same, w_stableNow, w_isNew, w_reportable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= SEG_BLANK;
      r_sync2 <= SEG_BLANK;
      r_prev  <= SEG_BLANK;
    end else begin
      r_sync1 <= seg_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  seg7_pattern_decode u_decode (
    .i_pattern (r_prev),
    .o_digit   (w_digit),
    .o_blank   (w_blank),
    .o_error   (w_error)
  );

  assign w_same      = (r_sync2 == r_prev);
  assign w_stableNow = w_same && (r_count == CNT_LAST);
  assign w_isNew     = !r_hasReported || (r_prev != r_lastReported);

`ifdef SEG7_BLANK_REPORT_EN
  assign w_reportable = 1'b1;
`else
  assign w_reportable = !w_blank;
  assign out_blank    = 1'b0;
`endif

  // The count saturates at CNT_MAX while a record waits, so a pattern already
  // stable on acceptance parks in HOLD instead of being re-counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= TRACK;
      r_count        <= '0;
      r_lastReported <= SEG_BLANK;
      r_hasReported  <= 1'b0;
      r_held         <= SEG_BLANK;
      out_valid      <= 1'b0;
      out_digit      <= 4'h0;
      out_error      <= 1'b0;
      overrun        <= 1'b0;
`ifdef SEG7_BLANK_REPORT_EN
      out_blank      <= 1'b0;
`endif
    end else begin
      case (r_state)
        TRACK: begin
          if (!w_same) begin
            r_count <= '0;
          end else if (w_stableNow) begin
            if (w_isNew && w_reportable) begin
              r_state   <= EMIT;
              r_count   <= CNT_MAX;
              r_held    <= r_prev;
              out_valid <= 1'b1;
              out_digit <= w_digit;
              out_error <= w_error;
`ifdef SEG7_BLANK_REPORT_EN
              out_blank <= w_blank;
`endif
            end else begin
              r_state        <= HOLD;
              r_lastReported <= r_prev;
              r_hasReported  <= 1'b1;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        EMIT: begin
          if (!w_same) begin
            r_count <= '0;
          end else if (r_count != CNT_MAX) begin
            r_count <= r_count + 1'b1;
            if (w_stableNow && (r_prev != r_held)) overrun <= 1'b1;
          end
          if (out_ready) begin
            r_state        <= (w_same && (w_stableNow || r_count == CNT_MAX)) ? HOLD : TRACK;
            out_valid      <= 1'b0;
            r_lastReported <= r_held;
            r_hasReported  <= 1'b1;
          end
        end
        HOLD: begin
          if (!w_same) begin
            r_state <= TRACK;
            r_count <= '0;
          end
        end
        default: r_state <= TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_pattern_capture.sv
// Directed bench for seg7_pattern_capture; a queue scoreboard holds the records each step should produce.
// Honours SEG7_BLANK_REPORT_EN the same way as the design.
module tb_seg7_pattern_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:1] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_error;
  logic       overrun;

  int vectors     = 0;
  int miscompares = 0;
  logic [5:0] expQ[$];

  always #5 clk = ~clk;

  seg7_pattern_capture #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_digit (out_digit),
    .out_blank (out_blank),
    .out_error (out_error),
    .overrun   (overrun)
  );

  function automatic logic [5:0] rec(input logic err, input logic blank, input logic [3:0] d);
    return {err, blank, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:1] pattern, input int cycles);
    seg_in = pattern;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitDrained(input string tag, input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) @(negedge clk);
    checkOutput(tag, 8'(expQ.size()), 8'd0);
  endtask

  // Records are sampled 1 ns before the accepting edge; 8'hFF marks "no record expected".
  always begin
    @(negedge clk);
    #4;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0)
        checkOutput("unexpected_record", {2'b00, out_error, out_blank, out_digit}, 8'hFF);
      else
        checkOutput("record", {2'b00, out_error, out_blank, out_digit}, {2'b00, expQ.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset = 1'b1; seg_in = 7'h7F; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid",   8'(out_valid), 8'd0);
    checkOutput("reset_digit",   8'(out_digit), 8'd0);
    checkOutput("reset_blank",   8'(out_blank), 8'd0);
    checkOutput("reset_error",   8'(out_error), 8'd0);
    checkOutput("reset_overrun", 8'(overrun),   8'd0);

    // Digit 0 latency: record appears after edge E0+6 and is not repeated.
    out_ready = 1'b1;
    expQ.push_back(rec(1'b0, 1'b0, 4'h0));
    seg_in = 7'h40;
    reset  = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t1_valid_early", 8'(out_valid), 8'd0);
    @(negedge clk);
    checkOutput("t1_valid_on_time", 8'(out_valid), 8'd1);
    checkOutput("t1_digit", 8'(out_digit), 8'd0);
    repeat (20) @(negedge clk);
    waitDrained("t1_drain", 4);

    // Glitch: 2 held too briefly, only 3 is reported.
    expQ.push_back(rec(1'b0, 1'b0, 4'h3));
    applyStimulus(7'h24, 3);
    applyStimulus(7'h30, 20);
    waitDrained("t2_drain", 4);

    // Backpressure: 4 held while 5 becomes stable and is dropped.
    out_ready = 1'b0;
    expQ.push_back(rec(1'b0, 1'b0, 4'h4));
    applyStimulus(7'h19, 12);
    checkOutput("t3_valid_held", 8'(out_valid), 8'd1);
    checkOutput("t3_digit_held", 8'(out_digit), 8'd4);
    applyStimulus(7'h12, 14);
    checkOutput("t3_overrun", 8'(overrun), 8'd1);
    checkOutput("t3_still_valid", 8'(out_valid), 8'd1);
    checkOutput("t3_digit_kept", 8'(out_digit), 8'd4);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    waitDrained("t3_drain", 4);
    checkOutput("t3_valid_fell", 8'(out_valid), 8'd0);
    repeat (12) @(negedge clk);

    // Invalid, blank, then digits reappearing after them.
    expQ.push_back(rec(1'b1, 1'b0, 4'h0));
    applyStimulus(7'h7E, 14);
`ifdef SEG7_BLANK_REPORT_EN
    expQ.push_back(rec(1'b0, 1'b1, 4'h0));
`endif
    applyStimulus(7'h7F, 14);
    expQ.push_back(rec(1'b0, 1'b0, 4'h0));
    applyStimulus(7'h40, 14);
    expQ.push_back(rec(1'b0, 1'b0, 4'h5));
    applyStimulus(7'h12, 14);
    waitDrained("t4_drain", 4);
    checkOutput("t4_overrun_sticky", 8'(overrun), 8'd1);

    // Same digit across a reset is reported again.
    expQ.push_back(rec(1'b0, 1'b0, 4'h1));
    applyStimulus(7'h79, 14);
    waitDrained("t5_first", 4);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    expQ.push_back(rec(1'b0, 1'b0, 4'h1));
    reset = 1'b0;
    repeat (14) @(negedge clk);
    waitDrained("t5_again", 4);

    // Asynchronous reset while a record is pending with overrun set.
    out_ready = 1'b0;
    expQ.push_back(rec(1'b0, 1'b0, 4'h9));
    applyStimulus(7'h18, 14);
    applyStimulus(7'h00, 14);
    checkOutput("t6_valid_pending", 8'(out_valid), 8'd1);
    checkOutput("t6_overrun_set", 8'(overrun), 8'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_async_valid", 8'(out_valid), 8'd0);
    checkOutput("t6_async_overrun", 8'(overrun), 8'd0);
    expQ.delete();
    @(negedge clk);
    expQ.push_back(rec(1'b0, 1'b0, 4'h8));
    out_ready = 1'b1;
    reset     = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t6_valid_early", 8'(out_valid), 8'd0);
    @(negedge clk);
    checkOutput("t6_valid_on_time", 8'(out_valid), 8'd1);
    checkOutput("t6_digit", 8'(out_digit), 8'd8);
    waitDrained("t6_drain", 4);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
